// File: rtl/ctr_cmd_pkg.sv
// Shared types for the counter command sequencer and its command FIFO.
package ctr_cmd_pkg;

   localparam int CMD_ARG_W = 4;

   typedef enum logic [1:0] {
      OP_NOP     = 2'b00,
      OP_LOAD    = 2'b01,
      OP_STEP_UP = 2'b10,
      OP_STEP_DN = 2'b11
   } ctr_op_e;

   typedef struct packed {
      ctr_op_e              op;
      logic [CMD_ARG_W-1:0] arg;
   } ctr_cmd_t;

   typedef enum logic {
      ST_IDLE,
      ST_EXEC
   } seq_state_e;

   function automatic logic is_step(input ctr_op_e op);
      return (op == OP_STEP_UP) || (op == OP_STEP_DN);
   endfunction

endpackage

// File: rtl/ctr_cmd_fifo.sv
// Command FIFO: power-of-two depth, pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module ctr_cmd_fifo
   import ctr_cmd_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  ctr_cmd_t         din,
   input  logic             pop,
   output ctr_cmd_t         dout,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = 1;

   ctr_cmd_t       mem [DEPTH];
   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   logic [PTR_W:0] count;
   logic           do_push;
   logic           do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign count   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign level   = LVL_W'(count);
   assign dout    = mem[rd_ptr[PTR_W-1:0]];

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // NOTE: storage is not reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr[PTR_W-1:0]] <= din;
   end

endmodule

// File: rtl/ctr_cmd_sequencer.sv
// Expands buffered commands into cycle-exact load / step / idle control for the
// mod-12 counter. Outputs are registered and describe the command popped at the previous edge.
module ctr_cmd_sequencer
   import ctr_cmd_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [CMD_ARG_W-1:0] cmd_arg,
   input  logic                 flush,
   output logic                 ctr_load,
   output logic [CMD_ARG_W-1:0] ctr_load_val,
   output logic                 ctr_up_down,
   output logic                 ctr_enable,
   output logic                 busy,
   output logic                 cmd_done,
   output logic [LVL_W-1:0]     fifo_level
);

   localparam logic [CMD_ARG_W-1:0] REM_ONE = 1;

   ctr_cmd_t             push_cmd;
   ctr_cmd_t             head;
   logic                 push;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   seq_state_e           state;
   seq_state_e           state_nx;
   logic [CMD_ARG_W-1:0] rem;
   logic [CMD_ARG_W-1:0] rem_nx;
   logic                 load_nx;
   logic [CMD_ARG_W-1:0] load_val_nx;
   logic                 up_down_nx;
   logic                 enable_nx;
   logic                 busy_nx;
   logic                 done_nx;

   assign cmd_ready    = !fifo_full && !flush && !rst;
   assign push         = cmd_valid && cmd_ready;
   assign push_cmd.op  = ctr_op_e'(cmd_op);
   assign push_cmd.arg = cmd_arg;

   ctr_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (push),
      .din   (push_cmd),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         rem   <= '0;
      end else begin
         state <= state_nx;
         rem   <= rem_nx;
      end
   end

   // rem counts the cycles still owed after the current one; the next pop happens when it hits 0.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      state_nx = state;
      rem_nx   = rem;
      pop      = 1'b0;
      if (flush) begin
         state_nx = ST_IDLE;
         rem_nx   = '0;
      end else if (state == ST_EXEC && rem != '0) begin
         rem_nx = rem - REM_ONE;
      end else if (!fifo_empty) begin
         pop      = 1'b1;
         state_nx = ST_EXEC;
         rem_nx   = (head.op == OP_LOAD) ? '0 : head.arg;
      end else begin
         state_nx = ST_IDLE;
      end
   end

   always_comb begin
      load_nx     = 1'b0;
      enable_nx   = 1'b0;
      busy_nx     = 1'b0;
      done_nx     = 1'b0;
      load_val_nx = ctr_load_val;
      up_down_nx  = ctr_up_down;
      if (pop) begin
         busy_nx = 1'b1;
         done_nx = (head.op == OP_LOAD) || (head.arg == '0);
         if (head.op == OP_LOAD) begin
            load_nx     = 1'b1;
            load_val_nx = head.arg;
         end else if (is_step(head.op)) begin
            enable_nx  = 1'b1;
            up_down_nx = (head.op == OP_STEP_UP);
         end
      end else if (state_nx == ST_EXEC) begin
         // A multi-cycle step or NOP continues; loads never reach here.
         busy_nx   = 1'b1;
         enable_nx = ctr_enable;
         done_nx   = (rem_nx == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctr_load     <= 1'b0;
         ctr_load_val <= '0;
         ctr_up_down  <= 1'b1;
         ctr_enable   <= 1'b0;
         busy         <= 1'b0;
         cmd_done     <= 1'b0;
      end else begin
         ctr_load     <= load_nx;
         ctr_load_val <= load_val_nx;
         ctr_up_down  <= up_down_nx;
         ctr_enable   <= enable_nx;
         busy         <= busy_nx;
         cmd_done     <= done_nx;
      end
   end

endmodule

// File: tb/tb_ctr_cmd_sequencer.sv
// Scoreboard bench: accepted commands are expanded into per-cycle expectations,
// a negedge monitor consumes them whenever the sequencer should be active.
module tb_ctr_cmd_sequencer;
   import ctr_cmd_pkg::*;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_arg;
   logic       flush;
   logic       ctr_load;
   logic [3:0] ctr_load_val;
   logic       ctr_up_down;
   logic       ctr_enable;
   logic       busy;
   logic       cmd_done;
   logic [2:0] fifo_level;

   ctr_cmd_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_arg      (cmd_arg),
      .flush        (flush),
      .ctr_load     (ctr_load),
      .ctr_load_val (ctr_load_val),
      .ctr_up_down  (ctr_up_down),
      .ctr_enable   (ctr_enable),
      .busy         (busy),
      .cmd_done     (cmd_done),
      .fifo_level   (fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      int op;
      int arg;
      bit first;
      bit last;
      int avail;
      int gen;
   } rec_t;

   rec_t rec_q[$];
   int   edge_n    = 0;
   int   gen       = 0;
   int   acc_cnt   = 0;
   int   pop_cnt   = 0;
   int   seen_gen  = 0;
   int   rd_idx    = 0;
   int   last_val  = 0;
   bit   last_ud   = 1'b1;
   int   checks    = 0;
   int   errors    = 0;
   bit   drain_req = 1'b0;
   bit   drain_chk = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   // One record per active cycle; a command may start no earlier than one edge after its push.
   task automatic expand(input int op, input int arg, input int avail, input int g);
      int n;
      n = (op == int'(OP_LOAD)) ? 1 : arg + 1;
      for (int i = 0; i < n; i++)
         rec_q.push_back('{op: op, arg: arg, first: (i == 0), last: (i == n - 1),
                           avail: avail, gen: g});
   endtask

   // Acceptance recorder: mirrors the handshake rule from the model's own occupancy.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         gen     <= gen + 1;
         acc_cnt <= 0;
      end else begin
         edge_n <= edge_n + 1;
         if (flush) begin
            gen     <= gen + 1;
            acc_cnt <= 0;
         end else if (cmd_valid && (acc_cnt - pop_cnt) < DEPTH) begin
            acc_cnt <= acc_cnt + 1;
            expand(int'(cmd_op), int'(cmd_arg), edge_n + 2, gen);
         end
      end
   end

   // Monitor: compares every cycle, consuming one expectation per active cycle.
   always @(negedge clk) begin
      bit   e_busy, e_done, e_load, e_en, e_ready;
      int   level;
      rec_t r;
      if (rst) begin
         rd_idx   = rec_q.size();
         pop_cnt  = 0;
         seen_gen = gen;
         last_val = 0;
         last_ud  = 1'b1;
         check("rst_strobes", {27'd0, ctr_load, ctr_enable, busy, cmd_done, cmd_ready}, 32'd0);
         check("rst_hold", {24'd0, ctr_load_val, ctr_up_down, fifo_level}, {24'd0, 4'd0, 1'b1, 3'd0});
      end else begin
         if (gen != seen_gen) begin
            seen_gen = gen;
            pop_cnt  = 0;
         end
         while (rd_idx < rec_q.size() && rec_q[rd_idx].gen != gen) rd_idx++;
         e_busy = 1'b0; e_done = 1'b0; e_load = 1'b0; e_en = 1'b0;
         if (rd_idx < rec_q.size() && rec_q[rd_idx].avail <= edge_n) begin
            r = rec_q[rd_idx];
            rd_idx++;
            if (r.first) pop_cnt++;
            e_busy = 1'b1;
            e_done = r.last;
            e_load = (r.op == int'(OP_LOAD));
            e_en   = (r.op == int'(OP_STEP_UP)) || (r.op == int'(OP_STEP_DN));
            if (e_load) last_val = r.arg;
            if (e_en)   last_ud  = (r.op == int'(OP_STEP_UP));
         end
         level   = acc_cnt - pop_cnt;
         e_ready = (level < DEPTH) && !flush;
         check("busy_done", {30'd0, busy, cmd_done}, {30'd0, e_busy, e_done});
         check("load_enable", {30'd0, ctr_load, ctr_enable}, {30'd0, e_load, e_en});
         check("load_val", {28'd0, ctr_load_val}, last_val);
         check("up_down", {31'd0, ctr_up_down}, {31'd0, last_ud});
         check("fifo_level", {29'd0, fifo_level}, level);
         check("cmd_ready", {31'd0, cmd_ready}, {31'd0, e_ready});
         if (drain_req && !drain_chk) begin
            check("drained", rec_q.size() - rd_idx, 32'd0);
            drain_chk = 1'b1;
         end
      end
   end

   task automatic push_cmd(input logic [1:0] op, input logic [3:0] arg);
      int waited = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      @(negedge clk);
      while (!cmd_ready) begin
         waited++;
         if (waited > 200) begin
            $display("FAIL push_timeout: cmd_ready low for %0d cycles, required 1", waited);
            $fatal(1, "push handshake never completed");
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_arg   = 4'd0;
      flush     = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(1);

      // Single load, then a 4-cycle step up from 10.
      push_cmd(OP_LOAD, 4'd13);
      idle(3);
      push_cmd(OP_LOAD, 4'd10);
      push_cmd(OP_STEP_UP, 4'd3);
      idle(6);

      // Back-to-back queue with no bubbles.
      push_cmd(OP_STEP_DN, 4'd0);
      push_cmd(OP_NOP, 4'd2);
      push_cmd(OP_LOAD, 4'd5);
      idle(8);

      // Fill the FIFO behind a long step; the last push must wait for a pop.
      push_cmd(OP_STEP_UP, 4'd15);
      push_cmd(OP_LOAD, 4'd7);
      push_cmd(OP_NOP, 4'd1);
      push_cmd(OP_STEP_DN, 4'd2);
      push_cmd(OP_STEP_UP, 4'd0);
      push_cmd(OP_LOAD, 4'd11);
      idle(30);

      // Flush in the second active cycle of a step, with two queued and a valid in the flush cycle.
      push_cmd(OP_STEP_UP, 4'd7);
      push_cmd(OP_LOAD, 4'd3);
      push_cmd(OP_NOP, 4'd4);
      flush     = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = OP_LOAD;
      cmd_arg   = 4'd9;
      idle(1);
      flush     = 1'b0;
      cmd_valid = 1'b0;
      idle(4);

      // Asynchronous reset in the middle of a step down.
      push_cmd(OP_STEP_DN, 4'd9);
      idle(3);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(4);

      for (int i = 0; i < 400; i++) begin
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_op    = 2'($urandom_range(0, 3));
         cmd_arg   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 2))
                                                 : 4'($urandom_range(0, 15));
         flush     = ($urandom_range(0, 39) == 0);
         idle(1);
      end
      cmd_valid = 1'b0;
      flush     = 1'b0;
      idle(100);

      drain_req = 1'b1;
      for (int k = 0; k < 10 && !drain_chk; k++) @(negedge clk);
      if (!drain_chk) begin
         $display("FAIL drain_timeout: final drain comparison never ran");
         $fatal(1, "drain comparison missing");
      end
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctr_cmd_sequencer.md
Name: ctr_cmd_sequencer

Overview:
Command front-end that sits directly upstream of the mod-12 loadable up/down counter and drives its load, load_val, up_down and enable inputs. It accepts short commands over a valid/ready handshake and buffers them in a small FIFO. Each command is expanded into a cycle-exact pattern of counter control: one load pulse, N count steps in a direction, or N idle cycles. This makes counter stimulus and scheduling deterministic for the rest of the design.

Parameters:
FIFO_DEPTH, 4, number of buffered commands (power of 2, >=2)
LVL_W, $clog2(FIFO_DEPTH+1), width of fifo_level

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  producer has a command
cmd_ready  output  1  block can accept a command
cmd_op  input  2  00 NOP, 01 LOAD, 10 STEP_UP, 11 STEP_DN
cmd_arg  input  4  LOAD: value; STEP/NOP: repeat count minus 1
flush  input  1  synchronous abort of current and queued commands
ctr_load  output  1  to counter load
ctr_load_val  output  4  to counter load_val
ctr_up_down  output  1  to counter up_down (1 = up)
ctr_enable  output  1  to counter enable
busy  output  1  a command is executing
cmd_done  output  1  high in the final active cycle of each command
fifo_level  output  LVL_W  queued commands, excluding the executing one

Behaviour:
- Reset (async, while rst high):
  - ctr_load=0, ctr_enable=0, ctr_load_val=0, ctr_up_down=1.
  - busy=0, cmd_done=0, fifo_level=0.
  - FIFO emptied; FSM in IDLE; cmd_ready=0 while rst high.
- Handshake:
  - cmd_ready = !full && !flush && !rst.
  - A command is pushed at an edge where cmd_valid && cmd_ready.
  - A push while full is impossible by construction.
- FSM states:
  - IDLE -> EXEC at an edge where the FIFO is non-empty: pop the head, load rem = (op==LOAD) ? 0 : cmd_arg.
  - EXEC, rem>0: rem decrements each edge.
  - EXEC, rem==0: pop the next command at the same edge if the FIFO is non-empty (no bubble); otherwise go to IDLE.
- Outputs are registered and describe the executing command in the cycle after its pop edge. Latency: a push into an empty FIFO with FSM in IDLE at edge E0 gives its first active cycle after edge E1.
- LOAD: ctr_load=1 for exactly 1 cycle; ctr_load_val=cmd_arg unmodified (the counter applies mod 12); ctr_enable=0.
- STEP_UP / STEP_DN: ctr_enable=1 for cmd_arg+1 consecutive cycles (1..16); ctr_up_down=1 or 0 for those cycles.
- NOP: all strobes 0 for cmd_arg+1 cycles; busy=1.
- Hold rules: ctr_load_val and ctr_up_down hold their last driven value when not loading or stepping. ctr_load and ctr_enable are never both 1.
- busy=1 in every active cycle of any command. cmd_done=1 in the last active cycle of each command.
- fifo_level updates on push/pop. A simultaneous push and pop leaves it unchanged.
- flush (sampled at edge):
  - FIFO cleared, FSM -> IDLE, rem=0.
  - ctr_load, ctr_enable, busy and cmd_done are 0 from the next cycle.
  - ctr_load_val and ctr_up_down hold.
  - A cmd_valid in the flush cycle is not accepted.
- Reset mid-command: everything returns to reset values immediately (async); no partial command resumes.
- Width rules: rem is 4 bits; no wrap possible. FIFO pointers are log2(FIFO_DEPTH) bits with an extra wrap bit for the full/empty distinction.

Decomposition:
- Package ctr_cmd_pkg:
  - enum ctr_op_e {OP_NOP, OP_LOAD, OP_STEP_UP, OP_STEP_DN}.
  - struct packed ctr_cmd_t {op, arg} (6 bits).
  - CMD_ARG_W=4.
- Sub-module ctr_cmd_fifo: parameterised synchronous FIFO of ctr_cmd_t with push, pop, full, empty, level and a synchronous clear (driven by flush).
- The sequencer FSM and output registers live in the top.

Test Plan:
- Reset release, then LOAD arg=13 pushed at E0 -> cycle after E1: ctr_load=1, ctr_load_val=13, cmd_done=1, busy=1; next cycle ctr_load=0, busy=0.
- STEP_UP arg=3 -> ctr_enable=1, ctr_up_down=1 for exactly 4 cycles; cmd_done only on the 4th; the downstream counter loaded at 10 reads 10->11->0->1->2.
- Back-to-back STEP_DN arg=0, NOP arg=2, LOAD arg=5 queued -> contiguous pattern: 1 step down, 3 idle busy cycles, 1 load cycle; no bubbles; cmd_done pulses 3 times.
- Fill FIFO_DEPTH=4 while a STEP arg=15 executes -> fifo_level=4, cmd_ready=0; after the next pop, level=3 and cmd_ready=1.
- flush in the 2nd cycle of STEP_UP arg=7 with 2 queued -> from the next cycle ctr_enable=0, busy=0, fifo_level=0; a cmd_valid in the flush cycle is dropped.
- rst asserted mid STEP_DN arg=9 -> outputs immediately at reset values (ctr_up_down=1, ctr_enable=0); after release, FSM in IDLE with an empty FIFO.
